// File: rtl/alu_defs.sv
`default_nettype none
// alu_defs: shared ALU opcodes and the divider sequencer state type.
// Rev 1.0
package alu_defs;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] ADD_ = 3'd0;
  localparam logic [OP_W-1:0] SUB_ = 3'd1;
  localparam logic [OP_W-1:0] AND_ = 3'd2;
  localparam logic [OP_W-1:0] OR_  = 3'd3;
  localparam logic [OP_W-1:0] XOR_ = 3'd4;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RUN  = 2'd1,
    DS_DONE = 2'd2
  } divseq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_divmod_seq_if.sv
`default_nettype none
// alu_divmod_seq_if: operand/opcode/flags bus between the divider and the shared ALU.
// Rev 1.0
interface alu_divmod_seq_if
  import alu_defs::*;
#(
  parameter int N = 8
);
  logic            alu_req_o;
  logic [N-1:0]    alu_a_o;
  logic [N-1:0]    alu_b_o;
  logic [OP_W-1:0] alu_op_o;
  logic [N-1:0]    alu_result_i;
  logic [1:0]      alu_flags_i;

  modport master (
    output alu_req_o, alu_a_o, alu_b_o, alu_op_o,
    input  alu_result_i, alu_flags_i
  );

  modport slave (
    input  alu_a_o, alu_b_o, alu_op_o,
    output alu_result_i, alu_flags_i
  );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// alu: combinational N-bit ALU; flags[0] = result zero, flags[1] = result MSB.
// Rev 1.0
module alu
  import alu_defs::*;
#(
  parameter int N = 8
) (
  alu_divmod_seq_if.slave bus
);
  logic [N-1:0] w_res;

  always_comb begin
    w_res = bus.alu_a_o;
    case (bus.alu_op_o)
      ADD_:    w_res = bus.alu_a_o + bus.alu_b_o;
      SUB_:    w_res = bus.alu_a_o - bus.alu_b_o;
      AND_:    w_res = bus.alu_a_o & bus.alu_b_o;
      OR_:     w_res = bus.alu_a_o | bus.alu_b_o;
      XOR_:    w_res = bus.alu_a_o ^ bus.alu_b_o;
      default: w_res = bus.alu_a_o;
    endcase
  end

  assign bus.alu_result_i = w_res;
  assign bus.alu_flags_i  = {w_res[N-1], (w_res == '0)};
endmodule
`default_nettype wire

// File: rtl/alu_divmod_seq.sv
`default_nettype none
// alu_divmod_seq: iterative unsigned x/m and x mod m by repeated SUB_ on the shared ALU.
// Rev 1.0
module alu_divmod_seq
  import alu_defs::*;
#(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N-1:0]   x_i,
  input  logic [N-1:0]   m_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [N-1:0]   q_o,
  output logic [N-1:0]   r_o,
  alu_divmod_seq_if.master alu
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  divseq_state_t state_q;
  logic [N-1:0]  r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  m_q;
  logic          err_q;
  logic          w_bad_op;
  logic          unused_zero_flag;

  // Operands with the MSB set would break the sign-flag compare, so reject them up front.
  assign w_bad_op = (m_i == '0) | x_i[N-1] | m_i[N-1];
  assign unused_zero_flag = alu.alu_flags_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DS_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (start_i) begin
            m_q <= m_i;
            q_q <= '0;
            if (w_bad_op) begin
              err_q   <= 1'b1;
              r_q     <= '0;
              state_q <= DS_DONE;
            end else begin
              err_q   <= 1'b0;
              r_q     <= x_i;
              state_q <= DS_RUN;
            end
          end
        end
        DS_RUN: begin
          if (!alu.alu_flags_i[1]) begin
            r_q <= alu.alu_result_i;
            q_q <= q_q + ONE;
          end else begin
            state_q <= DS_DONE;
          end
        end
        DS_DONE: state_q <= DS_IDLE;
        default: state_q <= DS_IDLE;
      endcase
    end
  end

  always_comb begin
    alu.alu_req_o = 1'b0;
    alu.alu_a_o   = '0;
    alu.alu_b_o   = '0;
    alu.alu_op_o  = '0;
    if (state_q == DS_RUN) begin
      alu.alu_req_o = 1'b1;
      alu.alu_a_o   = r_q;
      alu.alu_b_o   = m_q;
      alu.alu_op_o  = SUB_;
    end
  end

  assign busy_o = (state_q == DS_RUN);
  assign done_o = (state_q == DS_DONE);
  assign err_o  = err_q;
  assign q_o    = q_q;
  assign r_o    = r_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_divmod_seq.sv
`default_nettype none
// tb_alu_divmod_seq: directed vector table plus corner sequences for alu_divmod_seq + alu.
// Rev 1.0
module tb_alu_divmod_seq;
  import alu_defs::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [7:0] m_in = '0;
  logic       busy, done, err;
  logic [7:0] q, r;

  int total = 0;
  int bad = 0;

  alu_divmod_seq_if #(.N(8)) alu_bus ();

  alu_divmod_seq #(.N(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .x_i     (x_in),
    .m_i     (m_in),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .q_o     (q),
    .r_o     (r),
    .alu     (alu_bus.master)
  );

  alu #(.N(8)) u_alu (.bus(alu_bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] m;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives start just after edge E0; lat is the index k of edge Ek after which done is seen.
  task automatic run_job(input logic [7:0] x, input logic [7:0] m, input bit inject,
                         output int lat, output int req_cycles, output int busy_err);
    @(posedge clk); #1;
    start = 1'b1; x_in = x; m_in = m;
    lat = -1; req_cycles = 0; busy_err = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (inject && k >= 5 && k <= 15) begin
        start = 1'b1; x_in = 8'd5; m_in = 8'd0;
      end else begin
        start = 1'b0;
      end
      if (alu_bus.alu_req_o) req_cycles++;
      if (busy != alu_bus.alu_req_o) busy_err++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int lat, req_cycles, busy_err, nd, first_done, last_done, gap_err;

    vecs[0] = '{x:8'd13,  m:8'd4,   q:8'd3,   r:8'd1,  err:1'b0, lat:5};
    vecs[1] = '{x:8'd3,   m:8'd7,   q:8'd0,   r:8'd3,  err:1'b0, lat:2};
    vecs[2] = '{x:8'd9,   m:8'd9,   q:8'd1,   r:8'd0,  err:1'b0, lat:3};
    vecs[3] = '{x:8'd5,   m:8'd0,   q:8'd0,   r:8'd0,  err:1'b1, lat:1};
    vecs[4] = '{x:8'h80,  m:8'd1,   q:8'd0,   r:8'd0,  err:1'b1, lat:1};
    vecs[5] = '{x:8'd3,   m:8'h80,  q:8'd0,   r:8'd0,  err:1'b1, lat:1};
    vecs[6] = '{x:8'd127, m:8'd1,   q:8'd127, r:8'd0,  err:1'b0, lat:129};
    vecs[7] = '{x:8'd100, m:8'd7,   q:8'd14,  r:8'd2,  err:1'b0, lat:16};
    vecs[8] = '{x:8'd0,   m:8'd5,   q:8'd0,   r:8'd0,  err:1'b0, lat:2};
    vecs[9] = '{x:8'd64,  m:8'd127, q:8'd0,   r:8'd64, err:1'b0, lat:2};

    // Reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
    check("rst_req", int'(alu_bus.alu_req_o), 0);
    check("rst_op", int'(alu_bus.alu_op_o), 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_job(vecs[i].x, vecs[i].m, 1'b0, lat, req_cycles, busy_err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), int'(q), int'(vecs[i].q));
      check($sformatf("v%0d_r", i), int'(r), int'(vecs[i].r));
      check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].err));
      check($sformatf("v%0d_run_cycles", i), req_cycles,
            vecs[i].err ? 0 : int'(vecs[i].q) + 1);
      check($sformatf("v%0d_busy_eq_run", i), busy_err, 0);
      check($sformatf("v%0d_done_busy", i), int'(busy), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_hold_q", i), int'(q), int'(vecs[i].q));
    end

    // Start pulses (with an erroring operand pair) during RUN are ignored
    run_job(8'd127, 8'd1, 1'b1, lat, req_cycles, busy_err);
    check("inj_lat", lat, 129);
    check("inj_q", int'(q), 127);
    check("inj_r", int'(r), 0);
    check("inj_err", int'(err), 0);
    check("inj_busy", busy_err, 0);
    @(posedge clk); #1;
    check("inj_idle_req", int'(alu_bus.alu_req_o), 0);

    // Asynchronous reset in the middle of a RUN
    @(posedge clk); #1;
    start = 1'b1; x_in = 8'd100; m_in = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_req", int'(alu_bus.alu_req_o), 0);
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_r", int'(r), 0);
    check("mid_rst_a", int'(alu_bus.alu_a_o), 0);
    check("mid_rst_op", int'(alu_bus.alu_op_o), 0);
    @(negedge clk); rst_n = 1'b1;
    run_job(8'd10, 8'd3, 1'b0, lat, req_cycles, busy_err);
    check("post_rst_lat", lat, 5);
    check("post_rst_q", int'(q), 3);
    check("post_rst_r", int'(r), 1);
    check("post_rst_err", int'(err), 0);

    // Back-to-back with start held high: x=5, m=2 gives q=2, period q+3
    @(posedge clk); #1;
    start = 1'b1; x_in = 8'd5; m_in = 8'd2;
    nd = 0; first_done = -1; last_done = -1; gap_err = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first_done < 0) first_done = k;
        else if (k - last_done != 5) gap_err++;
        last_done = k;
        check("b2b_q", int'(q), 2);
        check("b2b_r", int'(r), 1);
      end
    end
    start = 1'b0;
    check("b2b_first", first_done, 4);
    check("b2b_count", nd, 6);
    check("b2b_period", gap_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_quiet", int'(done | busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
